// File: rtl/rsa_pkg.sv
// Shared constants, MonPro opcode encodings and sequencer state encoding
// for the RSA modular-exponentiation controller.
package rsa_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH  = 5;
  localparam int unsigned TOTAL_ADDR  = 2 ** ADDR_WIDTH;
  localparam int unsigned DATA_LENGTH = DATA_WIDTH * TOTAL_ADDR;
  localparam int unsigned BITS_W      = 11;
  localparam int unsigned CNT_W       = 12;

  typedef enum logic [2:0] {
    OP_NONE      = 3'd0,
    OP_TO_MONT   = 3'd1,
    OP_SQR       = 3'd2,
    OP_MUL       = 3'd3,
    OP_FROM_MONT = 3'd4,
    OP_LOAD_ONE  = 3'd5
  } mp_op_e;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_SCAN   = 4'd2,
    ST_ISSUE  = 4'd3,
    ST_WAIT   = 4'd4,
    ST_DONE   = 4'd5,
    ST_UNLOAD = 4'd6,
    ST_ERR    = 4'd7
  } state_e;

endpackage

// File: rtl/rsa_modexp_ctrl_if.sv
// Operand-load stream, MonPro start/done handshake and result-read stream.
// master = sequencer side, slave = datapath side.
interface rsa_modexp_ctrl_if;
  import rsa_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] e_input;
  logic                  op_wr_en;
  logic [ADDR_WIDTH-1:0] op_wr_addr;
  logic                  mp_start;
  mp_op_e                mp_op;
  logic                  mp_done;
  logic [ADDR_WIDTH-1:0] res_rd_addr;
  logic                  res_valid;

  modport master (
    input  in_valid, e_input, mp_done,
    output in_ready, op_wr_en, op_wr_addr, mp_start, mp_op, res_rd_addr, res_valid
  );

  modport slave (
    output in_valid, e_input, mp_done,
    input  in_ready, op_wr_en, op_wr_addr, mp_start, mp_op, res_rd_addr, res_valid
  );

endinterface

// File: rtl/rsa_exp_shift_reg.sv
// 1024-bit exponent store: word-indexed load, 1-bit left shift toward the
// MSB, MSB tap and all-zero detect.
module rsa_exp_shift_reg
  import rsa_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_idx,
  input  logic [DATA_WIDTH-1:0] load_word,
  input  logic                  shift_en,
  output logic                  msb,
  output logic                  is_zero
);

  logic [DATA_LENGTH-1:0] exp_q;

  // Word write has priority; shifting only happens after loading is complete.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q <= '0;
    end else if (load_en) begin
      exp_q[int'(load_idx) * DATA_WIDTH +: DATA_WIDTH] <= load_word;
    end else if (shift_en) begin
      exp_q <= {exp_q[DATA_LENGTH-2:0], 1'b0};
    end
  end

  assign msb     = exp_q[DATA_LENGTH-1];
  assign is_zero = (exp_q == '0);

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for the MonPro datapath.
// Optional MonPro watchdog enabled by defining RSA_MP_TIMEOUT_EN.
module rsa_modexp_ctrl
  import rsa_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     startInput,
  input  logic                     getResult,
  rsa_modexp_ctrl_if.master        bus,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         op_count,
  output logic                     err
);

  localparam logic [BITS_W-1:0] BITS_INIT = BITS_W'(DATA_LENGTH);

  state_e                state_q, state_d;
  mp_op_e                op_q, op_d;
  logic [ADDR_WIDTH-1:0] wc_q;
  logic [BITS_W-1:0]     bits_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  done_q;
  logic                  load_en, shift_en;
  logic                  exp_msb, exp_zero;
  logic                  wd_expired;

  rsa_exp_shift_reg u_exp (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_idx  (wc_q),
    .load_word (bus.e_input),
    .shift_en  (shift_en),
    .msb       (exp_msb),
    .is_zero   (exp_zero)
  );

`ifdef RSA_MP_TIMEOUT_EN
  logic [31:0] wd_q;

  // Cycles spent in WAIT for the current op; cleared whenever WAIT is left.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 wd_q <= '0;
    else if (state_q == ST_WAIT) wd_q <= wd_q + 32'd1;
    else                        wd_q <= '0;
  end

  assign wd_expired = (wd_q == TIMEOUT_CYCLES - 1);
  assign err        = (state_q == ST_ERR);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign wd_expired     = 1'b0;
  assign err            = 1'b0;
`endif

  // State, current opcode and the one-cycle done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      done_q  <= (state_q == ST_WAIT) && (state_d == ST_DONE);
    end
  end

  // Word counter (load and unload), remaining exponent bits, saturating op count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wc_q   <= '0;
      bits_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && startInput) begin
        wc_q  <= '0;
        cnt_q <= '0;
      end else if (load_en || state_q == ST_UNLOAD) begin
        wc_q <= wc_q + 5'd1;
      end
      if (state_q == ST_LOAD)  bits_q <= BITS_INIT;
      else if (shift_en)       bits_q <= bits_q - 11'd1;
      if (state_q == ST_ISSUE && cnt_q != '1) cnt_q <= cnt_q + 12'd1;
    end
  end

  // Next state and next op; every exponent shift also consumes one bit of bits_left.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    load_en  = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      ST_IDLE: if (startInput) state_d = ST_LOAD;
      ST_LOAD: begin
        if (bus.in_valid) begin
          load_en = 1'b1;
          if (wc_q == '1) state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (exp_zero) begin
          op_d    = OP_LOAD_ONE;
          state_d = ST_ISSUE;
        end else begin
          shift_en = 1'b1;
          if (exp_msb) begin
            op_d    = OP_TO_MONT;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.mp_done) begin
          state_d = ST_ISSUE;
          case (op_q)
            OP_FROM_MONT: state_d = ST_DONE;
            OP_LOAD_ONE:  op_d = OP_FROM_MONT;
            OP_SQR: begin
              // The squared bit is consumed here; bits_q still holds the pre-shift count.
              shift_en = 1'b1;
              if (exp_msb)                 op_d = OP_MUL;
              else if (bits_q == 11'd1)    op_d = OP_FROM_MONT;
              else                         op_d = OP_SQR;
            end
            default: op_d = (bits_q == 11'd0) ? OP_FROM_MONT : OP_SQR;
          endcase
        end else if (wd_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE:   if (getResult) state_d = ST_UNLOAD;
      ST_UNLOAD: if (wc_q == '1) state_d = ST_IDLE;
      ST_ERR:    state_d = ST_ERR;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready    = (state_q == ST_LOAD);
  assign bus.op_wr_en    = load_en;
  assign bus.op_wr_addr  = wc_q;
  assign bus.mp_start    = (state_q == ST_ISSUE);
  assign bus.mp_op       = op_q;
  assign bus.res_valid   = (state_q == ST_UNLOAD);
  assign bus.res_rd_addr = wc_q;
  assign busy            = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign done            = done_q;
  assign op_count        = cnt_q;

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Directed testbench for rsa_modexp_ctrl: a table of exponents with
// hand-computed MonPro op schedules, plus reset-abort and watchdog sequences.
module tb_rsa_modexp_ctrl;
  import rsa_pkg::*;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             startInput = 1'b0;
  logic             getResult = 1'b0;
  logic             busy, done, err;
  logic [CNT_W-1:0] op_count;

  rsa_modexp_ctrl_if bus ();

  rsa_modexp_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .startInput (startInput),
    .getResult  (getResult),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .op_count   (op_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int unsigned tests = 0;
  int unsigned fails = 0;
  bit          mp_auto = 1'b1;
  bit          spur_req = 1'b0;
  int unsigned last_done_cyc = 0;
  int unsigned last_start_cyc = 0;
  mp_op_e      op_log[$];

  typedef struct {
    logic [DATA_LENGTH-1:0] e;
    bit                     toggle;
    bit                     spur;
    int unsigned            n_ops;
    int unsigned            seq_len;
    mp_op_e                 seq [8];
  } vec_t;

  vec_t tbl [6];

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // MonPro model: logs every issued op and answers with mp_done three cycles later.
  initial begin : monpro
    int unsigned cnt = 0;
    bit          pend = 1'b0;
    bus.mp_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.mp_done = 1'b0;
      if (!reset) begin
        pend = 1'b0;
      end else begin
        if (spur_req) begin
          bus.mp_done = 1'b1;
          spur_req = 1'b0;
        end
        if (pend) begin
          if (cnt == 0) begin
            bus.mp_done   = 1'b1;
            pend          = 1'b0;
            last_done_cyc = cyc;
          end else begin
            cnt--;
          end
        end
        if (bus.mp_start) begin
          op_log.push_back(bus.mp_op);
          last_start_cyc = cyc;
          if (mp_auto) begin
            pend = 1'b1;
            cnt  = 2;
          end
        end
      end
    end
  end

  task automatic load_e(input logic [DATA_LENGTH-1:0] e, input bit toggle, input bit spur);
    int unsigned w = 0;
    int unsigned guard = 0;
    int unsigned bad_addr = 0, bad_inv = 0, bad_rdy = 0;
    bit          v;
    @(negedge clk); startInput = 1'b1;
    @(negedge clk); startInput = 1'b0;
    while (w < 32 && guard < 200) begin
      v = !toggle || (guard % 2 == 0);
      bus.in_valid = v;
      bus.e_input  = e[w*32 +: 32];
      if (spur && guard == 7) spur_req = 1'b1;
      #1;
      if (!bus.in_ready) bad_rdy++;
      if (bus.op_wr_en) begin
        if (!v) bad_inv++;
        if (bus.op_wr_addr != 5'(w)) bad_addr++;
        w++;
      end
      guard++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("load_write_count", w, 32);
    chk("load_addr_errors", bad_addr, 0);
    chk("load_write_while_invalid", bad_inv, 0);
    chk("load_in_ready_low", bad_rdy, 0);
  endtask

  task automatic run_vec(input int unsigned idx, input vec_t v);
    int unsigned guard = 0;
    int unsigned beats = 0;
    bit          seen = 1'b0;
    longint unsigned got;
    op_log.delete();
    load_e(v.e, v.toggle, v.spur);
    while (!seen && guard < 20000) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      guard++;
    end
    chk($sformatf("v%0d_done_seen", idx), seen, 1);
    chk($sformatf("v%0d_done_latency", idx), cyc - last_done_cyc, 1);
    chk($sformatf("v%0d_op_count", idx), op_count, v.n_ops);
    chk($sformatf("v%0d_ops_logged", idx), op_log.size(), v.n_ops);
    for (int unsigned i = 0; i < v.seq_len; i++) begin
      got = (i < op_log.size()) ? longint'(op_log[i]) : 7;
      chk($sformatf("v%0d_op%0d", idx, i), got, v.seq[i]);
    end
    got = (op_log.size() > 0) ? longint'(op_log[$]) : 7;
    chk($sformatf("v%0d_last_op", idx), got, OP_FROM_MONT);
    chk($sformatf("v%0d_busy_in_done", idx), busy, 0);
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", idx), done, 0);
    getResult = 1'b1;
    @(negedge clk);
    getResult = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (bus.res_valid && bus.res_rd_addr == 5'(i)) beats++;
      @(negedge clk);
    end
    chk($sformatf("v%0d_unload_beats", idx), beats, 32);
    chk($sformatf("v%0d_unload_end", idx), {bus.res_valid, busy}, 0);
  endtask

  function automatic longint unsigned outs();
    return {bus.in_ready, bus.op_wr_en, bus.op_wr_addr, bus.mp_start, bus.mp_op, busy, done,
            bus.res_rd_addr, bus.res_valid, op_count, err};
  endfunction

  initial begin : global_guard
    #3000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    int unsigned guard;

    tbl[0].e = 1024'h1;  tbl[0].toggle = 0; tbl[0].spur = 0; tbl[0].n_ops = 2;    tbl[0].seq_len = 2;
    tbl[0].seq = '{OP_TO_MONT, OP_FROM_MONT, OP_NONE, OP_NONE, OP_NONE, OP_NONE, OP_NONE, OP_NONE};
    tbl[1].e = 1024'hB;  tbl[1].toggle = 1; tbl[1].spur = 1; tbl[1].n_ops = 7;    tbl[1].seq_len = 7;
    tbl[1].seq = '{OP_TO_MONT, OP_SQR, OP_SQR, OP_MUL, OP_SQR, OP_MUL, OP_FROM_MONT, OP_NONE};
    tbl[2].e = '1;      tbl[2].toggle = 0; tbl[2].spur = 0; tbl[2].n_ops = 2048; tbl[2].seq_len = 8;
    tbl[2].seq = '{OP_TO_MONT, OP_SQR, OP_MUL, OP_SQR, OP_MUL, OP_SQR, OP_MUL, OP_SQR};
    tbl[3].e = '0;      tbl[3].toggle = 0; tbl[3].spur = 0; tbl[3].n_ops = 2;    tbl[3].seq_len = 2;
    tbl[3].seq = '{OP_LOAD_ONE, OP_FROM_MONT, OP_NONE, OP_NONE, OP_NONE, OP_NONE, OP_NONE, OP_NONE};
    tbl[4].e = {1'b1, 1023'b0};
    tbl[4].toggle = 0; tbl[4].spur = 0; tbl[4].n_ops = 1025; tbl[4].seq_len = 4;
    tbl[4].seq = '{OP_TO_MONT, OP_SQR, OP_SQR, OP_SQR, OP_NONE, OP_NONE, OP_NONE, OP_NONE};
    tbl[5].e = '0; tbl[5].e[32] = 1'b1; tbl[5].e[0] = 1'b1;
    tbl[5].toggle = 0; tbl[5].spur = 0; tbl[5].n_ops = 35; tbl[5].seq_len = 4;
    tbl[5].seq = '{OP_TO_MONT, OP_SQR, OP_SQR, OP_SQR, OP_NONE, OP_NONE, OP_NONE, OP_NONE};

    bus.in_valid = 1'b0;
    bus.e_input  = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", outs(), 0);

    for (int unsigned i = 0; i < 6; i++) run_vec(i, tbl[i]);

    // Abort with reset while the third op (SQR) is outstanding.
    op_log.delete();
    load_e(tbl[1].e, 1'b0, 1'b0);
    guard = 0;
    while (op_log.size() < 3 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    chk("pre_abort_op", bus.mp_op, OP_SQR);
    chk("pre_abort_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_outputs", outs(), 0);
    @(negedge clk);
    reset = 1'b1;
    run_vec(10, tbl[0]);

`ifdef RSA_MP_TIMEOUT_EN
    mp_auto = 1'b0;
    op_log.delete();
    load_e(tbl[0].e, 1'b0, 1'b0);
    guard = 0;
    while (!err && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("wd_err_set", err, 1);
    chk("wd_latency", cyc - last_start_cyc, 17);
    chk("wd_busy", busy, 0);
    startInput = 1'b1;
    @(negedge clk);
    startInput = 1'b0;
    repeat (3) @(negedge clk);
    chk("wd_err_sticky", err, 1);
    chk("wd_start_ignored", {busy, bus.in_ready}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
